// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types for the register responder: address/data/strobe types,
// response codes, FSM state encodings and the address range decode helper.
// Pure type/function package, no ports, no latency, no flow control.
package axi_lite_pkg;

   typedef logic [11:0] addr_t;
   typedef logic [31:0] data_t;
   typedef logic [3:0]  strb_t;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } wstate_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rstate_t;

   // True when the byte address falls inside a bank of nregs 32-bit words.
   function automatic logic addr_in_range(input addr_t addr, input int unsigned nregs);
      return ({20'd0, addr} < (nregs * 4));
   endfunction

endpackage

// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) with master/slave views.
// Wires only, no latency.
// Flow control is plain valid/ready per channel; no buffering in the interface.
interface axi_lite_slave_regs_if;
   import axi_lite_pkg::*;

   addr_t awaddr;
   logic  awvalid;
   logic  awready;
   data_t wdata;
   strb_t wstrb;
   logic  wvalid;
   logic  wready;
   resp_t bresp;
   logic  bvalid;
   logic  bready;
   addr_t araddr;
   logic  arvalid;
   logic  arready;
   data_t rdata;
   resp_t rresp;
   logic  rvalid;
   logic  rready;

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/axi_lite_regfile.sv
// NREGS x 32-bit register storage: synchronous byte-enabled write, async read.
// Write visible after the clock edge; read is combinational from storage.
// No flow control: the caller decides when we_i is asserted.
// Ports: clk_i/rst_i (sync active-high, clears all words), we_i/widx_i/wdata_i/
//        wstrb_i write port, ridx_i/rdata_o read port.
module axi_lite_regfile
   import axi_lite_pkg::*;
#(
   parameter int NREGS = 16,
   parameter int IDX_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we_i,
   input  logic [IDX_W-1:0] widx_i,
   input  data_t            wdata_i,
   input  strb_t            wstrb_i,
   input  logic [IDX_W-1:0] ridx_i,
   output data_t            rdata_o
);

   data_t mem_q [NREGS];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_i[b]) begin
               mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   // Guard keeps a non-power-of-two bank from indexing past its end.
   always_comb begin
      rdata_o = '0;
      if (int'(ridx_i) < NREGS) begin
         rdata_o = mem_q[ridx_i];
      end
   end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite responder terminating reads/writes into NREGS 32-bit registers.
// Write: bvalid one cycle after the later of AW/W; read: rvalid one cycle after AR.
// Holds bvalid/rvalid until bready/rready; while a response is pending the
// matching address/data readies stay low.
// Ports: aclk, areset (sync active-high), bus (AXI4-Lite slave modport).
module axi_lite_slave_regs
   import axi_lite_pkg::*;
#(
   parameter int NREGS     = 16,
   parameter int USE_WSTRB = 0
) (
   input  logic                  aclk,
   input  logic                  areset,
   axi_lite_slave_regs_if.slave  bus
);

   localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

   // Write path state
   wstate_t wstate_q, wstate_d;
   logic    aw_held_q, aw_held_d;
   logic    w_held_q, w_held_d;
   addr_t   awaddr_q, awaddr_d;
   data_t   wdata_q, wdata_d;
   strb_t   wstrb_q, wstrb_d;
   resp_t   bresp_q, bresp_d;

   // Read path state
   rstate_t rstate_q, rstate_d;
   data_t   rdata_q, rdata_d;
   resp_t   rresp_q, rresp_d;

   logic             aw_hs, w_hs, ar_hs, commit;
   logic             wr_in_range, rd_in_range, rf_we;
   addr_t            cur_awaddr;
   data_t            cur_wdata;
   strb_t            cur_wstrb, rf_wstrb;
   logic [IDX_W-1:0] widx, ridx;
   data_t            rf_rdata;

   // ---------------------------------------------------------------
   // Handshakes and decode
   // ---------------------------------------------------------------
   always_comb begin
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid  && bus.wready;
      ar_hs = bus.arvalid && bus.arready;

      // A beat is either already held or arriving this cycle.
      cur_awaddr = aw_held_q ? awaddr_q : bus.awaddr;
      cur_wdata  = w_held_q  ? wdata_q  : bus.wdata;
      cur_wstrb  = w_held_q  ? wstrb_q  : bus.wstrb;

      commit      = (wstate_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
      wr_in_range = addr_in_range(cur_awaddr, NREGS);
      rd_in_range = addr_in_range(bus.araddr, NREGS);

      rf_we    = commit && wr_in_range;
      // The legacy master drives wstrb = 0, so strobes are ignored unless enabled.
      rf_wstrb = (USE_WSTRB != 0) ? cur_wstrb : 4'hF;
      widx     = cur_awaddr[2 +: IDX_W];
      ridx     = bus.araddr[2 +: IDX_W];
   end

   axi_lite_regfile #(
      .NREGS (NREGS),
      .IDX_W (IDX_W)
   ) u_regfile (
      .clk_i   (aclk),
      .rst_i   (areset),
      .we_i    (rf_we),
      .widx_i  (widx),
      .wdata_i (cur_wdata),
      .wstrb_i (rf_wstrb),
      .ridx_i  (ridx),
      .rdata_o (rf_rdata)
   );

   // ---------------------------------------------------------------
   // Write FSM
   // ---------------------------------------------------------------
   always_ff @(posedge aclk) begin
      if (areset) begin
         wstate_q  <= W_IDLE;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bresp_q   <= OKAY;
      end else begin
         wstate_q  <= wstate_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bresp_q   <= bresp_d;
      end
   end

   always_comb begin
      wstate_d  = wstate_q;
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bresp_d   = bresp_q;
      case (wstate_q)
         W_IDLE: begin
            if (aw_hs) begin
               aw_held_d = 1'b1;
               awaddr_d  = bus.awaddr;
            end
            if (w_hs) begin
               w_held_d = 1'b1;
               wdata_d  = bus.wdata;
               wstrb_d  = bus.wstrb;
            end
            // Commit overrides the latch-and-hold above: both beats are consumed.
            if (commit) begin
               wstate_d  = W_RESP;
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               bresp_d   = wr_in_range ? OKAY : SLVERR;
            end
         end
         W_RESP: begin
            if (bus.bready) begin
               wstate_d = W_IDLE;
            end
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   always_comb begin
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      bus.bvalid  = 1'b0;
      bus.bresp   = bresp_q;
      case (wstate_q)
         W_IDLE: begin
            bus.awready = !aw_held_q;
            bus.wready  = !w_held_q;
         end
         W_RESP: bus.bvalid = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------
   // Read FSM
   // ---------------------------------------------------------------
   always_ff @(posedge aclk) begin
      if (areset) begin
         rstate_q <= R_IDLE;
         rdata_q  <= '0;
         rresp_q  <= OKAY;
      end else begin
         rstate_q <= rstate_d;
         rdata_q  <= rdata_d;
         rresp_q  <= rresp_d;
      end
   end

   // The regfile read is sampled before any same-edge write lands, so a
   // colliding read returns the pre-write value.
   always_comb begin
      rstate_d = rstate_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      case (rstate_q)
         R_IDLE: begin
            if (ar_hs) begin
               rstate_d = R_DATA;
               rdata_d  = rd_in_range ? rf_rdata : '0;
               rresp_d  = rd_in_range ? OKAY : SLVERR;
            end
         end
         R_DATA: begin
            if (bus.rready) begin
               rstate_d = R_IDLE;
            end
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   always_comb begin
      bus.arready = 1'b0;
      bus.rvalid  = 1'b0;
      bus.rdata   = rdata_q;
      bus.rresp   = rresp_q;
      case (rstate_q)
         R_IDLE:  bus.arready = 1'b1;
         R_DATA:  bus.rvalid  = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed bench for axi_lite_slave_regs: two instances share one stimulus,
// u_dut0 with full-word writes and u_dut1 honouring wstrb.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_axi_lite_slave_regs;
   import axi_lite_pkg::*;

   logic aclk = 1'b0;
   logic areset;
   always #5 aclk = ~aclk;

   addr_t awaddr, araddr;
   data_t wdata;
   strb_t wstrb;
   logic  awvalid, wvalid, bready, arvalid, rready;

   axi_lite_slave_regs_if if0 ();
   axi_lite_slave_regs_if if1 ();

   assign if0.awaddr  = awaddr;   assign if1.awaddr  = awaddr;
   assign if0.awvalid = awvalid;  assign if1.awvalid = awvalid;
   assign if0.wdata   = wdata;    assign if1.wdata   = wdata;
   assign if0.wstrb   = wstrb;    assign if1.wstrb   = wstrb;
   assign if0.wvalid  = wvalid;   assign if1.wvalid  = wvalid;
   assign if0.bready  = bready;   assign if1.bready  = bready;
   assign if0.araddr  = araddr;   assign if1.araddr  = araddr;
   assign if0.arvalid = arvalid;  assign if1.arvalid = arvalid;
   assign if0.rready  = rready;   assign if1.rready  = rready;

   axi_lite_slave_regs #(.NREGS(16), .USE_WSTRB(0)) u_dut0 (
      .aclk   (aclk),
      .areset (areset),
      .bus    (if0.slave)
   );

   axi_lite_slave_regs #(.NREGS(16), .USE_WSTRB(1)) u_dut1 (
      .aclk   (aclk),
      .areset (areset),
      .bus    (if1.slave)
   );

   int    checks = 0;
   int    errors = 0;
   data_t last_rdata1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".awready"}, 32'(if0.awready), 32'd1);
      chk({tag, ".wready"},  32'(if0.wready),  32'd1);
      chk({tag, ".arready"}, 32'(if0.arready), 32'd1);
      chk({tag, ".bvalid"},  32'(if0.bvalid),  32'd0);
      chk({tag, ".rvalid"},  32'(if0.rvalid),  32'd0);
   endtask

   // AW and W together, bready high: response must appear the next cycle.
   task automatic do_write(input string tag, input addr_t a, input data_t d,
                           input strb_t s, input logic [1:0] exp_resp);
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      chk({tag, ".bvalid"}, 32'(if0.bvalid), 32'd1);
      chk({tag, ".bresp"},  32'(if0.bresp),  32'(exp_resp));
      tick();
      chk({tag, ".bvalid_clr"}, 32'(if0.bvalid), 32'd0);
      bready = 1'b0;
   endtask

   task automatic read_chk(input string tag, input addr_t a, input data_t exp_d,
                           input logic [1:0] exp_resp);
      araddr = a; arvalid = 1'b1; rready = 1'b0;
      tick();
      arvalid = 1'b0;
      chk({tag, ".rvalid"}, 32'(if0.rvalid), 32'd1);
      chk({tag, ".rdata"},  if0.rdata,       exp_d);
      chk({tag, ".rresp"},  32'(if0.rresp),  32'(exp_resp));
      last_rdata1 = if1.rdata;
      rready = 1'b1;
      tick();
      rready = 1'b0;
   endtask

   initial begin
      areset = 1'b1;
      awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;

      // Reset state, during and just after reset
      tick(); tick();
      chk_idle("in_rst");
      chk("in_rst.bresp", 32'(if0.bresp), 32'd0);
      chk("in_rst.rdata", if0.rdata, 32'd0);
      areset = 1'b0;
      tick();
      chk_idle("post_rst");

      // Write with AW+W in the same cycle; wstrb = 0 still writes the full word
      do_write("wr_same", 12'h004, 32'hA5A5_1234, 4'b0000, 2'b00);
      read_chk("rd_004", 12'h004, 32'hA5A5_1234, 2'b00);
      chk("rd_004.arready_back", 32'(if0.arready), 32'd1);

      // W three cycles ahead of AW
      bready = 1'b1;
      wdata = 32'h0000_00FF; wstrb = 4'hF; wvalid = 1'b1;
      chk("wfirst.wready_pre", 32'(if0.wready), 32'd1);
      tick();
      wvalid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("wfirst.wready_held", 32'(if0.wready),  32'd0);
         chk("wfirst.awready",     32'(if0.awready), 32'd1);
         chk("wfirst.bvalid_wait", 32'(if0.bvalid),  32'd0);
         if (c < 2) tick();
      end
      awaddr = 12'h010; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      chk("wfirst.bvalid", 32'(if0.bvalid), 32'd1);
      chk("wfirst.bresp",  32'(if0.bresp),  32'd0);
      chk("wfirst.wready_resp", 32'(if0.wready), 32'd0);
      tick();
      chk("wfirst.bvalid_clr", 32'(if0.bvalid), 32'd0);
      chk("wfirst.wready_back", 32'(if0.wready), 32'd1);
      bready = 1'b0;
      read_chk("rd_010", 12'h010, 32'h0000_00FF, 2'b00);

      // Out-of-range write and read; in-range contents untouched
      do_write("wr_oor", 12'h040, 32'hDEAD_BEEF, 4'hF, 2'b10);
      read_chk("rd_oor", 12'h100, 32'h0, 2'b10);
      read_chk("rd_000_untouched", 12'h000, 32'h0, 2'b00);
      read_chk("rd_004_untouched", 12'h004, 32'hA5A5_1234, 2'b00);
      read_chk("rd_010_untouched", 12'h010, 32'h0000_00FF, 2'b00);

      // Byte strobes: u_dut1 merges lanes, u_dut0 writes the full word
      do_write("wr_008_full", 12'h008, 32'h1122_3344, 4'hF, 2'b00);
      do_write("wr_008_strb", 12'h008, 32'hAABB_CCDD, 4'b0101, 2'b00);
      read_chk("rd_008_nostrb", 12'h008, 32'hAABB_CCDD, 2'b00);
      chk("rd_008_strb", last_rdata1, 32'h11BB_33DD);

      // Backpressure with a same-edge read of the register being written
      bready = 1'b0; rready = 1'b0;
      awaddr = 12'h004; wdata = 32'h1234_5678; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      araddr = 12'h004; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      wdata = 32'h8765_4321;     // still offered, must not be taken
      for (int c = 0; c < 5; c++) begin
         chk("bp.bvalid",  32'(if0.bvalid),  32'd1);
         chk("bp.bresp",   32'(if0.bresp),   32'd0);
         chk("bp.rvalid",  32'(if0.rvalid),  32'd1);
         chk("bp.rdata",   if0.rdata,        32'hA5A5_1234);
         chk("bp.awready", 32'(if0.awready), 32'd0);
         chk("bp.wready",  32'(if0.wready),  32'd0);
         chk("bp.arready", 32'(if0.arready), 32'd0);
         tick();
      end
      awvalid = 1'b0; wvalid = 1'b0;
      bready = 1'b1; rready = 1'b1;
      tick();
      chk_idle("bp_release");
      bready = 1'b0; rready = 1'b0;
      read_chk("rd_004_after_bp", 12'h004, 32'h1234_5678, 2'b00);

      // Reset while both channels are holding a response
      awaddr = 12'h010; wdata = 32'h5555_5555; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      araddr = 12'h008; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      chk("mid.bvalid", 32'(if0.bvalid), 32'd1);
      chk("mid.rvalid", 32'(if0.rvalid), 32'd1);
      areset = 1'b1;
      tick();
      chk_idle("mid_rst");
      areset = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) begin
         read_chk("rst_clear", addr_t'(i * 4), 32'h0, 2'b00);
         if (i == 2) chk("rst_clear.dut1", last_rdata1, 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_lite_slave_regs.md
# axi_lite_slave_regs

AXI4-Lite responder that terminates read and write transactions into a bank of NREGS 32-bit memory-mapped registers. It is the slave end of the axi_lite_master links in the interconnect testbench and the default target for bring-up and protocol-compliance tests. Read and write channels run independently, and the block latches every address and data beat so masters may drop them after the handshake.

## Interface
- NREGS, 16: number of 32-bit registers; decoded byte range 0 .. NREGS*4-1.
- USE_WSTRB, 0: 1 = honour wstrb per byte; 0 = every accepted write updates the full word, since the existing master drives wstrb = 4'b0000.
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  reset, synchronous, active-high.
- awaddr  in  12 (addr_t)  write address.
- awvalid  in  1 / awready  out  1  write address handshake.
- wdata  in  32 (data_t) / wstrb  in  4 (strb_t)  write data and byte enables.
- wvalid  in  1 / wready  out  1  write data handshake.
- bresp  out  2 (resp_t) / bvalid  out  1 / bready  in  1  write response channel.
- araddr  in  12 (addr_t) / arvalid  in  1 / arready  out  1  read address channel.
- rdata  out  32 (data_t) / rresp  out  2 (resp_t) / rvalid  out  1 / rready  in  1  read data channel.

## Operation
- Decode: word index = addr[5:2] (generally addr[2+:$clog2(NREGS)]). addr[1:0] is ignored. Any address >= NREGS*4 is out of range.
- Write FSM states:
  - W_IDLE. awready = !aw_held, wready = !w_held. An AW handshake latches awaddr and sets aw_held. A W handshake latches wdata/wstrb and sets w_held. AW and W may arrive in either order or in the same cycle.
  - Commit. On the edge where both beats are present (held, or handshaking that cycle), the FSM goes to W_RESP.
    - In range: write the register (byte lanes gated by wstrb only if USE_WSTRB = 1), bresp = OKAY (2'b00).
    - Out of range: no register changes, bresp = SLVERR (2'b10).
    - Clear both held flags.
  - W_RESP. bvalid = 1, awready = wready = 0. bresp is stable until the B handshake, then back to W_IDLE.
- Read FSM states:
  - R_IDLE. arready = 1. An AR handshake registers rdata and rresp and moves to R_DATA.
    - In range: rdata = register value, rresp = OKAY.
    - Out of range: rdata = 0, rresp = SLVERR.
  - R_DATA. rvalid = 1, arready = 0. rdata/rresp are stable until the R handshake, then back to R_IDLE.
- Same-edge read/write to one register: the read captures the pre-write value. The write is still committed.
- Register contents reset to 0.

## Timing
- During reset and in the first cycle after it, all outputs are 0 except awready = wready = arready = 1 (FSMs in IDLE, held flags clear). Register bank is all zero.
- Reset asserted mid-transaction aborts it at that edge. Pending beats and responses are discarded, and no partial write occurs unless the commit edge already passed.
- Read latency: AR handshake at edge k gives rvalid = 1 from cycle k+1. With rready held high, one read completes every 2 cycles.
- Write latency: the second of AW/W accepted at edge k gives the register updated at edge k and bvalid = 1 from cycle k+1. With everything held high, one write completes every 2 cycles.
- Valid outputs never drop without the matching ready. The block never waits on a ready before raising a valid. Outputs come from state or registers only, with no combinational path from inputs.
- bready asserted early (before bvalid) is legal and costs no extra cycle.

## Structure
- axi_lite_pkg gains:
  - strb_t (logic [3:0]).
  - resp_t enum: OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11.
  - Existing addr_t (12 bits) and data_t (32 bits) are reused.
- Sub-module axi_lite_regfile: NREGS x 32 storage with synchronous write, 4-bit byte-enable write and an asynchronous read port. The top level holds both FSMs, the held flags and the decode logic.

## Test plan
- Reset, then write 0xA5A5_1234 to 0x004 (AW and W same cycle, bready = 1), then read 0x004 -> bresp OKAY, bvalid in cycle k+1; rdata = 0xA5A5_1234, rresp OKAY.
- W is presented 3 cycles before AW (addr 0x010, data 0x0000_00FF). wready drops after the W beat until bvalid clears. The read back returns 0x0000_00FF.
- Out-of-range write to 0x040 and read from 0x100 -> bresp SLVERR, rresp SLVERR with rdata 0. All registers unchanged.
- USE_WSTRB = 1: register 0x008 holds 0x1122_3344; write 0xAABB_CCDD with wstrb 4'b0101 -> reads 0x11BB_33DD. With USE_WSTRB = 0 the same stimulus reads 0xAABB_CCDD.
- Backpressure: hold bready = 0 and rready = 0 for 5 cycles -> bvalid/rvalid and bresp/rdata stay stable, awready/wready/arready stay low, and there is no second commit.
- Reset asserted while in W_RESP and R_DATA -> next cycle bvalid = rvalid = 0, all readies 1, and all registers read 0.
